// File: rtl/cmp_arbiter_pkg.sv
// Shared types for the compare arbiter: FSM state encoding.
package cmp_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/cmp.sv
// Recursive magnitude comparator: splits operands in halves until ORDER reaches LIMIT,
// then merges high/low verdicts (high half dominates unless equal).
module cmp #(
    parameter int ORDER = 3,
    parameter int LIMIT = 0
) (
    input  logic [2**ORDER-1:0] a,
    input  logic [2**ORDER-1:0] b,
    output logic                lt,
    output logic                eq,
    output logic                gt
);

    generate
        if (ORDER <= LIMIT) begin : g_leaf
            assign lt = (a < b);
            assign eq = (a == b);
            assign gt = (a > b);
        end else begin : g_split
            localparam int H = 2**(ORDER-1);
            logic hi_lt, hi_eq, hi_gt;
            logic lo_lt, lo_eq, lo_gt;

            cmp #(.ORDER(ORDER-1), .LIMIT(LIMIT)) u_hi (
                .a (a[2*H-1:H]),
                .b (b[2*H-1:H]),
                .lt(hi_lt),
                .eq(hi_eq),
                .gt(hi_gt)
            );

            cmp #(.ORDER(ORDER-1), .LIMIT(LIMIT)) u_lo (
                .a (a[H-1:0]),
                .b (b[H-1:0]),
                .lt(lo_lt),
                .eq(lo_eq),
                .gt(lo_gt)
            );

            assign lt = hi_lt | (hi_eq & lo_lt);
            assign eq = hi_eq & lo_eq;
            assign gt = hi_gt | (hi_eq & lo_gt);
        end
    endgenerate

endmodule

// File: rtl/cmp_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping mod N.
module cmp_arbiter_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    always_comb begin
        any = 1'b0;
        idx = '0;
        // Scan from the farthest offset down so the nearest eligible one wins.
        for (int off = N - 1; off >= 0; off--) begin
            int pos;
            pos = int'(ptr) + off;
            if (pos >= N) pos = pos - N;
            if (eligible[pos]) begin
                any = 1'b1;
                idx = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Shares one comparator among N requesters: round-robin pick in IDLE, compare in EXEC,
// registered lt/eq/gt and a one-cycle done pulse to the served requester.
module cmp_arbiter
    import cmp_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int ORDER = 3,
    parameter int LIMIT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic [N*(2**ORDER)-1:0] a,
    input  logic [N*(2**ORDER)-1:0] b,
    output logic [N-1:0]     grant,
    output logic [N-1:0]     done,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             busy
);

    localparam int W  = 2**ORDER;
    localparam int IW = $clog2(N);

    state_t        state_reg, state_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [W-1:0]  a_reg, a_next;
    logic [W-1:0]  b_reg, b_next;
    logic [N-1:0]  done_reg, done_next;
    logic          lt_reg, lt_next;
    logic          eq_reg, eq_next;
    logic          gt_reg, gt_next;

    logic [W-1:0]  a_arr [N];
    logic [W-1:0]  b_arr [N];
    logic [N-1:0]  eligible;
    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic          c_lt, c_eq, c_gt;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign a_arr[gi] = a[gi*W +: W];
            assign b_arr[gi] = b[gi*W +: W];
            assign grant[gi] = (state_reg == ST_EXEC) && (idx_reg == IW'(gi));
        end
    endgenerate

    // A requester seeing its done this cycle may still hold req; don't serve it again yet.
    assign eligible = req & ~done_reg;

    cmp_arbiter_rr_pick #(.N(N), .IW(IW)) u_pick (
        .eligible(eligible),
        .ptr     (ptr_reg),
        .any     (pick_any),
        .idx     (pick_idx)
    );

    cmp #(.ORDER(ORDER), .LIMIT(LIMIT)) u_cmp (
        .a (a_reg),
        .b (b_reg),
        .lt(c_lt),
        .eq(c_eq),
        .gt(c_gt)
    );

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        done_next  = '0;
        lt_next    = lt_reg;
        eq_next    = eq_reg;
        gt_next    = gt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (pick_any) begin
                    state_next = ST_EXEC;
                    idx_next   = pick_idx;
                    a_next     = a_arr[pick_idx];
                    b_next     = b_arr[pick_idx];
                    ptr_next   = (pick_idx == IW'(N - 1)) ? '0 : pick_idx + 1'b1;
                end
            end
            ST_EXEC: begin
                state_next = ST_IDLE;
                done_next  = N'(1) << idx_reg;
                lt_next    = c_lt;
                eq_next    = c_eq;
                gt_next    = c_gt;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            done_reg  <= '0;
            lt_reg    <= 1'b0;
            eq_reg    <= 1'b0;
            gt_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            done_reg  <= done_next;
            lt_reg    <= lt_next;
            eq_reg    <= eq_next;
            gt_reg    <= gt_next;
        end
    end

    assign done = done_reg;
    assign lt   = lt_reg;
    assign eq   = eq_reg;
    assign gt   = gt_reg;
    assign busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter (N=4, W=8): expected done/result pushed at stimulus,
// popped by a negedge monitor whenever done pulses; grants checked cycle by cycle.
module tb_cmp_arbiter;

    localparam int N     = 4;
    localparam int ORDER = 3;
    localparam int W     = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           lt, eq, gt, busy;

    cmp_arbiter #(.N(N), .ORDER(ORDER), .LIMIT(0)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .a    (a),
        .b    (b),
        .grant(grant),
        .done (done),
        .lt   (lt),
        .eq   (eq),
        .gt   (gt),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] d;
        logic [2:0]   r;   // {lt,eq,gt}
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [2:0] R_LT = 3'b100;
    localparam logic [2:0] R_EQ = 3'b010;
    localparam logic [2:0] R_GT = 3'b001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input int idx, input logic [2:0] res);
        exp_t e;
        e.d = '0;
        e.d[idx] = 1'b1;
        e.r = res;
        sb.push_back(e);
    endtask

    task automatic set_op(input int idx, input logic [W-1:0] av, input logic [W-1:0] bv);
        a[idx*W +: W] = av;
        b[idx*W +: W] = bv;
    endtask

    function automatic logic [N-1:0] onehot(input int idx);
        logic [N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done !== '0) begin
            if (sb.size() == 0) begin
                check("done_unexpected", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_idx", 32'(done), 32'(e.d));
                check("done_res", 32'({lt, eq, gt}), 32'(e.r));
                $display("txn: done=%b lt=%b eq=%b gt=%b t=%0t", done, lt, eq, gt, $time);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        req   = '1;
        a     = '0;
        b     = '0;

        // 1: reset with all requesting; first grant after release goes to 0.
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_res", 32'({lt, eq, gt}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        push(0, R_EQ);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_first_grant", 32'(grant), 32'(4'b0001));
        check("exec_busy", 32'(busy), 32'h1);
        req = '0;
        repeat (2) @(negedge clk);

        // 2: single requester, latency t+1 grant, t+2 done, lt.
        set_op(0, 8'h10, 8'h20);
        req = 4'b0001;
        push(0, R_LT);
        @(negedge clk);
        check("single_grant", 32'(grant), 32'(4'b0001));
        check("single_nodone", 32'(done), 32'h0);
        @(negedge clk);
        check("single_done", 32'(done), 32'(4'b0001));
        check("single_res", 32'({lt, eq, gt}), 32'(R_LT));
        check("single_grant_off", 32'(grant), 32'h0);
        req = '0;
        @(negedge clk);
        check("single_hold", 32'({lt, eq, gt}), 32'(R_LT));

        // 3: all equal, all requesting from ptr=0: order 0,1,2,3,0 one grant every 2 cycles.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 8'h5A, 8'h5A);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) push(i % N, R_EQ);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j % 2 == 0) check("rr_grant", 32'(grant), 32'(onehot((j / 2) % N)));
            else            check("rr_gap", 32'(grant), 32'h0);
            if (j == 8) req = '0;
        end
        @(negedge clk);

        // 4: one requester holding req: masked in its done cycle, re-granted after.
        set_op(2, 8'hFF, 8'h01);
        req = 4'b0100;
        for (int i = 0; i < 3; i++) push(2, R_GT);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check("mask_grant", 32'(grant), (j % 3 == 0) ? 32'(4'b0100) : 32'h0);
            check("mask_overlap", 32'(grant & done), 32'h0);
            if (j == 6) req = '0;
        end
        @(negedge clk);

        // 5a: ptr=3, req=1001 -> 3 then 0.
        set_op(3, 8'h03, 8'h07);
        set_op(0, 8'h09, 8'h09);
        req = 4'b1001;
        push(3, R_LT);
        push(0, R_EQ);
        @(negedge clk);
        check("wrap_grant3", 32'(grant), 32'(4'b1000));
        @(negedge clk);
        check("wrap_gap", 32'(grant), 32'h0);
        @(negedge clk);
        check("wrap_grant0", 32'(grant), 32'(4'b0001));
        req = '0;
        @(negedge clk);

        // Serve 2 once to bring ptr back to 3.
        req = 4'b0100;
        push(2, R_GT);
        @(negedge clk);
        check("ptr_setup_grant", 32'(grant), 32'(4'b0100));
        req = '0;
        @(negedge clk);

        // 5b: ptr=3, req=0110 -> 1 then 2.
        set_op(1, 8'h80, 8'h7F);
        req = 4'b0110;
        push(1, R_GT);
        push(2, R_GT);
        @(negedge clk);
        check("skip_grant1", 32'(grant), 32'(4'b0010));
        @(negedge clk);
        check("skip_gap", 32'(grant), 32'h0);
        @(negedge clk);
        check("skip_grant2", 32'(grant), 32'(4'b0100));
        req = '0;
        @(negedge clk);

        // 6: reset during EXEC aborts the op; ptr returns to 0.
        set_op(0, 8'h01, 8'h02);
        req = 4'b0001;
        @(negedge clk);
        check("abort_grant", 32'(grant), 32'(4'b0001));
        rst_n = 1'b0;
        #1;
        check("abort_grant_clr", 32'(grant), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_res", 32'({lt, eq, gt}), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        req = '0;
        repeat (2) @(negedge clk);
        check("abort_no_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        req = 4'b1001;
        push(0, R_LT);
        push(3, R_LT);
        @(negedge clk);
        check("post_rst_ptr", 32'(grant), 32'(4'b0001));
        @(negedge clk);
        @(negedge clk);
        check("post_rst_next", 32'(grant), 32'(4'b1000));
        req = '0;
        repeat (3) @(negedge clk);

        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
